branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumes resolved-branch results from the branch functional unit and compares each one against the prediction made in the front end.
- On a mispredict, sequences a redirect and flush handshake to fetch and discards queued wrong-path results.
- Emits a one-cycle predictor/RAS update for every branch it retires.
- Sits between the OoO branch FU output and the fetch/BPU.

Parameters:
XLEN, 32, datapath/PC width
DEPTH, 4, resolution FIFO entries (power of 2, >=2)
TAG_W, 6, ROB tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  resolution packet valid (from branch FU)
in_ready  out  1  FIFO not full (combinational from occupancy)
taken_in  in  1  actual direction
target_in  in  XLEN  actual target when taken
link_in  in  1  instruction writes link (call)
pc_in  in  XLEN  branch PC
pred_taken_in  in  1  predicted direction
pred_target_in  in  XLEN  predicted target
tag_in  in  TAG_W  ROB tag of branch
redirect_valid  out  1  redirect request to fetch
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  correct next PC
redirect_tag  out  TAG_W  tag of mispredicted branch (ROB flushes younger)
upd_valid  out  1  one-cycle predictor update pulse
upd_pc  out  XLEN  PC of retired branch
upd_taken  out  1  actual direction
upd_target  out  XLEN  actual target
upd_link  out  1  link flag for RAS
upd_mispredict  out  1  update corresponds to a mispredict
mispredict_cnt  out  16  saturating mispredict counter
overflow_err  out  1  sticky: valid_in seen while in_ready=0

Behaviour:
- Reset (async, rst=1): FIFO empty, state IDLE, all outputs 0. in_ready=1 once rst deasserts. mispredict_cnt=0, overflow_err=0.
- Enqueue:
  - When valid_in && in_ready, the packet is written at the FIFO tail on the clock edge.
  - valid_in && !in_ready drops the packet and sets overflow_err, which stays set until reset.
- FSM states: IDLE, REDIRECT.
- IDLE with FIFO non-empty, on each edge:
  - Pop the head.
  - Register the upd_* outputs from the head; upd_valid=1 for exactly that cycle.
  - mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - correct_pc = taken ? target : pc + 4, computed mod 2^XLEN with wrap-around and no carry out.
  - If mispredict: redirect_valid<=1, redirect_pc<=correct_pc, redirect_tag<=tag, mispredict_cnt increments (saturating at 0xFFFF), state<=REDIRECT.
- Throughput and latency:
  - One branch is retired per cycle in IDLE.
  - A packet accepted at edge k drives upd_valid/redirect_valid after edge k+1 when the FIFO was empty before edge k.
  - Simultaneous push and pop is legal; occupancy is unchanged.
- IDLE with FIFO empty: upd_valid=0, no state change.
- REDIRECT:
  - No pops. redirect_valid, redirect_pc and redirect_tag are held stable until the cycle in which redirect_ready=1.
  - New packets may still enqueue while not full.
- Handshake (redirect_valid && redirect_ready at an edge):
  - redirect_valid<=0.
  - FIFO flushed to empty. This includes a packet presented on valid_in in the same cycle, which is dropped and not counted as overflow. in_ready stays 1 that cycle.
  - state<=IDLE. Processing resumes the next cycle.
- redirect_ready while not in REDIRECT is ignored.
- upd_valid is never high in a cycle after the handshake edge unless a new post-flush packet has been popped.
- Pointers are log2(DEPTH)+1 bits so the wrap bit distinguishes full from empty.
  - Full: write and read indices equal, wrap bits differ.
  - Empty: full pointers equal.
- Reset asserted mid-REDIRECT: redirect_valid drops immediately (async), FIFO empties, state returns to IDLE.

Test Plan:
1. Correctly predicted not-taken: pc=0x100, taken=0, pred_taken=0 -> upd_valid pulse 2 edges after valid_in with upd_taken=0 and upd_mispredict=0; redirect_valid stays 0; mispredict_cnt=0.
2. Direction mispredict: pc=0x200, taken=1, target=0x400, pred_taken=0, tag=5; redirect_ready held low 3 cycles -> redirect_valid=1, redirect_pc=0x400, redirect_tag=5, all held stable for 3 cycles; drops the cycle after ready; mispredict_cnt=1.
3. Target mispredict and not-taken correction:
   - taken=1, target=0x800, pred_target=0x804 -> redirect_pc=0x800.
   - taken=0, pred_taken=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
4. Flush: mispredict at head, then 3 more packets pushed during REDIRECT plus one on the handshake cycle -> after handshake FIFO is empty, no upd_valid for those 4, in_ready=1, overflow_err=0.
5. Full/overflow: redirect_ready=0 with a mispredict held, push DEPTH packets -> in_ready=0; a fifth valid_in sets overflow_err and that packet never appears on upd_*.
6. Reset mid-REDIRECT: assert rst while redirect_valid=1 -> redirect_valid, upd_valid and mispredict_cnt go to 0 asynchronously; after release a new correctly predicted branch retires normally.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution: queues resolved-branch packets, compares them against the front-end
// prediction, emits predictor updates and runs the redirect/flush handshake on mispredicts.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic             taken_in,
  input  logic [XLEN-1:0]  target_in,
  input  logic             link_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [TAG_W-1:0] redirect_tag,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_link,
  output logic             upd_mispredict,
  output logic [15:0]      mispredict_cnt,
  output logic             overflow_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef struct packed {
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             link;
    logic [XLEN-1:0]  pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [TAG_W-1:0] tag;
  } pkt_t;

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e           state_q, state_d;
  pkt_t             mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop, handshake;
  pkt_t             head, wr_pkt;
  logic             head_mispredict;
  logic [XLEN-1:0]  correct_pc;

  logic             redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [TAG_W-1:0] redirect_tag_q;
  logic             upd_valid_q, upd_taken_q, upd_link_q, upd_mispredict_q;
  logic [XLEN-1:0]  upd_pc_q, upd_target_q;
  logic [15:0]      mispredict_cnt_q;
  logic             overflow_err_q;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = !rst && !full;
  assign handshake = (state_q == StRedirect) && redirect_valid_q && redirect_ready;
  // A packet arriving on the handshake edge is wrong-path and is discarded with the flush.
  assign push      = valid_in && in_ready && !handshake;
  assign pop       = (state_q == StIdle) && !empty;

  assign head            = mem_q[rd_ptr_q[IdxW-1:0]];
  assign head_mispredict = (head.taken != head.pred_taken) ||
                           (head.taken && (head.target != head.pred_target));
  assign correct_pc      = head.taken ? head.target : head.pc + XLEN'(4);

  assign wr_pkt = '{taken: taken_in, target: target_in, link: link_in, pc: pc_in,
                    pred_taken: pred_taken_in, pred_target: pred_target_in, tag: tag_in};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pop && head_mispredict) state_d = StRedirect;
      StRedirect: if (handshake) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IdxW-1:0]] <= wr_pkt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      redirect_tag_q   <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      upd_link_q       <= 1'b0;
      upd_mispredict_q <= 1'b0;
      mispredict_cnt_q <= '0;
      overflow_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (handshake) begin
        rd_ptr_q         <= wr_ptr_q;
        redirect_valid_q <= 1'b0;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (pop) begin
        upd_pc_q         <= head.pc;
        upd_taken_q      <= head.taken;
        upd_target_q     <= head.target;
        upd_link_q       <= head.link;
        upd_mispredict_q <= head_mispredict;
        if (head_mispredict) begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= correct_pc;
          redirect_tag_q   <= head.tag;
          if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
      end
      if (valid_in && !in_ready && !handshake) overflow_err_q <= 1'b1;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign redirect_tag   = redirect_tag_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign upd_link       = upd_link_q;
  assign upd_mispredict = upd_mispredict_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for single-branch retirement plus
// hand-written flush, overflow, throughput and async-reset sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, in_ready, taken_in, link_in, pred_taken_in;
  logic [31:0] target_in, pc_in, pred_target_in;
  logic [5:0]  tag_in;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [5:0]  redirect_tag;
  logic        upd_valid, upd_taken, upd_link, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [15:0] mispredict_cnt;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready), .taken_in(taken_in),
    .target_in(target_in), .link_in(link_in), .pc_in(pc_in), .pred_taken_in(pred_taken_in),
    .pred_target_in(pred_target_in), .tag_in(tag_in), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .redirect_tag(redirect_tag),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_link(upd_link), .upd_mispredict(upd_mispredict), .mispredict_cnt(mispredict_cnt),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        link;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  tag;
    logic        exp_mis;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic lk, input logic ptk, input logic [31:0] ptg,
                       input logic [5:0] tag);
    valid_in = v; pc_in = pc; taken_in = tk; target_in = tg; link_in = lk;
    pred_taken_in = ptk; pred_target_in = ptg; tag_in = tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd1, 1'b0, 32'h0};
    vecs[1] = '{32'h200, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 6'd5, 1'b1, 32'h400};
    vecs[2] = '{32'h300, 1'b1, 32'h800, 1'b0, 1'b1, 32'h804, 6'd7, 1'b1, 32'h800};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b0, 1'b1, 32'h40, 6'd9, 1'b1, 32'h0};
    vecs[4] = '{32'h500, 1'b1, 32'h600, 1'b1, 1'b1, 32'h600, 6'd2, 1'b0, 32'h0};
    vecs[5] = '{32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h999, 6'd3, 1'b0, 32'h0};

    rst = 1'b1;
    redirect_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd0);
    #12;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_cnt", 32'(mispredict_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-branch retirement table.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].link, vecs[i].pred_taken,
            vecs[i].pred_target, vecs[i].tag);
      tick();
      valid_in = 1'b0;
      chk("v_no_early_upd", 32'(upd_valid), 32'd0);
      tick();
      if (vecs[i].exp_mis) exp_cnt++;
      chk("v_upd_valid", 32'(upd_valid), 32'd1);
      chk("v_upd_pc", upd_pc, vecs[i].pc);
      chk("v_upd_taken", 32'(upd_taken), 32'(vecs[i].taken));
      chk("v_upd_target", upd_target, vecs[i].target);
      chk("v_upd_link", 32'(upd_link), 32'(vecs[i].link));
      chk("v_upd_mispredict", 32'(upd_mispredict), 32'(vecs[i].exp_mis));
      chk("v_redirect_valid", 32'(redirect_valid), 32'(vecs[i].exp_mis));
      chk("v_cnt", 32'(mispredict_cnt), 32'(exp_cnt));
      if (vecs[i].exp_mis) begin
        for (int c = 0; c < 3; c++) begin
          chk("v_hold_valid", 32'(redirect_valid), 32'd1);
          chk("v_hold_pc", redirect_pc, vecs[i].exp_rpc);
          chk("v_hold_tag", 32'(redirect_tag), 32'(vecs[i].tag));
          tick();
          chk("v_hold_no_upd", 32'(upd_valid), 32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("v_redirect_drop", 32'(redirect_valid), 32'd0);
      end else begin
        tick();
        chk("v_upd_pulse_end", 32'(upd_valid), 32'd0);
      end
    end

    // Back-to-back retirement, one per cycle.
    drive(1'b1, 32'hA00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd4);
    tick();
    drive(1'b1, 32'hB00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd6);
    tick();
    valid_in = 1'b0;
    chk("b2b_first_valid", 32'(upd_valid), 32'd1);
    chk("b2b_first_pc", upd_pc, 32'hA00);
    tick();
    chk("b2b_second_valid", 32'(upd_valid), 32'd1);
    chk("b2b_second_pc", upd_pc, 32'hB00);
    tick();
    chk("b2b_idle", 32'(upd_valid), 32'd0);

    // Flush: three pushes during REDIRECT plus one on the handshake edge.
    drive(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 6'd11);
    tick();
    valid_in = 1'b0;
    tick();
    exp_cnt++;
    chk("fl_redirect", 32'(redirect_valid), 32'd1);
    chk("fl_tag", 32'(redirect_tag), 32'd11);
    drive(1'b1, 32'hC00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd12);
    repeat (3) tick();
    redirect_ready = 1'b1;
    chk("fl_in_ready_hs", 32'(in_ready), 32'd1);
    tick();
    valid_in = 1'b0;
    redirect_ready = 1'b0;
    chk("fl_redirect_drop", 32'(redirect_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_overflow", 32'(overflow_err), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("fl_no_upd", 32'(upd_valid), 32'd0);
      tick();
    end
    chk("fl_cnt", 32'(mispredict_cnt), 32'(exp_cnt));

    // Full FIFO and overflow while a redirect is held.
    drive(1'b1, 32'h3000, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 6'd20);
    tick();
    valid_in = 1'b0;
    tick();
    exp_cnt++;
    drive(1'b1, 32'hD00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'd21);
    repeat (4) tick();
    chk("ov_full", 32'(in_ready), 32'd0);
    chk("ov_pre_err", 32'(overflow_err), 32'd0);
    pc_in = 32'hBAD0;
    tick();
    valid_in = 1'b0;
    chk("ov_err", 32'(overflow_err), 32'd1);
    chk("ov_still_full", 32'(in_ready), 32'd0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("ov_redirect_drop", 32'(redirect_valid), 32'd0);
    chk("ov_in_ready", 32'(in_ready), 32'd1);
    chk("ov_err_sticky", 32'(overflow_err), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk("ov_no_upd", 32'(upd_valid), 32'd0);
      tick();
    end
    chk("ov_cnt", 32'(mispredict_cnt), 32'(exp_cnt));

    // Reset asserted mid-REDIRECT, in the cycle the update pulse is high.
    drive(1'b1, 32'h4000, 1'b1, 32'h4400, 1'b0, 1'b0, 32'h0, 6'd30);
    tick();
    valid_in = 1'b0;
    tick();
    chk("rr_pre_redirect", 32'(redirect_valid), 32'd1);
    chk("rr_pre_upd", 32'(upd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_redirect_async", 32'(redirect_valid), 32'd0);
    chk("rr_upd_async", 32'(upd_valid), 32'd0);
    chk("rr_cnt_async", 32'(mispredict_cnt), 32'd0);
    chk("rr_overflow_async", 32'(overflow_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h5000, 1'b1, 32'h5100, 1'b0, 1'b1, 32'h5100, 6'd31);
    tick();
    valid_in = 1'b0;
    tick();
    chk("rr_post_upd", 32'(upd_valid), 32'd1);
    chk("rr_post_pc", upd_pc, 32'h5000);
    chk("rr_post_mis", 32'(upd_mispredict), 32'd0);
    chk("rr_post_redirect", 32'(redirect_valid), 32'd0);
    chk("rr_post_cnt", 32'(mispredict_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
